// File: rtl/csr_trap_ctrl.sv
// csr_trap_ctrl: machine-mode trap entry / MRET return sequencer.
// Owns the single CSR write port during a trap or MRET, otherwise passes EX-stage
// CSR writes straight through. Drives stall, flush and the fetch redirect.
module csr_trap_ctrl #(
    parameter logic [31:0] MSTATUS_ADDR = 32'h300,
    parameter logic [31:0] MTVEC_ADDR   = 32'h305,
    parameter logic [31:0] MEPC_ADDR    = 32'h341,
    parameter logic [31:0] MCAUSE_ADDR  = 32'h342,
    parameter logic [31:0] MTVAL_ADDR   = 32'h343
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        ex_csr_we_i,
    input  logic [31:0] ex_csr_waddr_i,
    input  logic [31:0] ex_csr_wdata_i,
    input  logic        exc_valid_i,
    input  logic [4:0]  exc_cause_i,
    input  logic [31:0] exc_pc_i,
    input  logic [31:0] exc_tval_i,
    input  logic        irq_ext_i,
    input  logic        irq_sw_i,
    input  logic        irq_timer_i,
    input  logic [31:0] irq_pc_i,
    input  logic        mret_i,
    input  logic [31:0] mstatus_i,
    input  logic [31:0] mie_i,
    input  logic [31:0] mtvec_i,
    input  logic [31:0] mepc_i,
    output logic        csr_we_o,
    output logic [31:0] csr_waddr_o,
    output logic [31:0] csr_wdata_o,
    output logic        stall_o,
    output logic        flush_o,
    output logic        redirect_valid_o,
    output logic [31:0] redirect_pc_o
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        W_MEPC    = 3'd1,
        W_MCAUSE  = 3'd2,
        W_MTVAL   = 3'd3,
        W_MSTATUS = 3'd4,
        MRET_WR   = 3'd5,
        REDIRECT  = 3'd6
    } state_e;

    // Interrupt sources, index 0 has the highest priority. The exception code
    // of each source equals its enable bit position in mie.
    localparam int          NUM_IRQ   = 3;
    localparam logic [14:0] IRQ_CODES = {5'd7, 5'd3, 5'd11}; // timer, sw, ext

    state_e state_reg, state_next;

    logic [31:0] pc_reg;
    logic [31:0] cause_reg;
    logic [31:0] tval_reg;
    logic [31:0] mstatus_reg;
    logic [31:0] mtvec_reg;
    logic        mret_reg;

    logic [NUM_IRQ-1:0] irq_line;
    logic [NUM_IRQ-1:0] irq_hit;
    logic [4:0]         irq_code;
    logic               irq_take;
    logic               idle;
    logic               trap_accept;
    logic               mret_accept;

    logic [31:0] trap_mstatus;
    logic [31:0] mret_mstatus;
    logic [31:0] trap_base;
    logic        trap_vectored;
    logic [31:0] trap_target;
    logic [31:0] redirect_target;

    // Only the mie enable bits of the three sources matter; fold the rest away.
    logic unused_ok;
    assign unused_ok = ^{MTVEC_ADDR, mie_i};

    assign irq_line = {irq_timer_i, irq_sw_i, irq_ext_i};

    generate
        for (genvar gi = 0; gi < NUM_IRQ; gi++) begin : g_irq_hit
            assign irq_hit[gi] = irq_line[gi] & mie_i[IRQ_CODES[gi*5 +: 5]];
        end
    endgenerate

    // Pick the highest-priority enabled pending interrupt (lowest index wins).
    always_comb begin
        irq_code = 5'd0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (irq_hit[i]) begin
                irq_code = IRQ_CODES[i*5 +: 5];
            end
        end
    end

    assign irq_take    = mstatus_i[3] & (|irq_hit);
    assign idle        = (state_reg == IDLE);
    assign trap_accept = idle & (exc_valid_i | irq_take);
    assign mret_accept = idle & ~exc_valid_i & ~irq_take & mret_i;

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic: fixed write sequence once a trap or MRET is accepted.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (trap_accept) begin
                    state_next = W_MEPC;
                end else if (mret_accept) begin
                    state_next = MRET_WR;
                end
            end
            W_MEPC:    state_next = W_MCAUSE;
            W_MCAUSE:  state_next = W_MTVAL;
            W_MTVAL:   state_next = W_MSTATUS;
            W_MSTATUS: state_next = REDIRECT;
            MRET_WR:   state_next = REDIRECT;
            REDIRECT:  state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    // Capture the trap/MRET context in the acceptance cycle so the sequence is
    // immune to the inputs changing while the pipeline is stalled.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pc_reg      <= '0;
            cause_reg   <= '0;
            tval_reg    <= '0;
            mstatus_reg <= '0;
            mtvec_reg   <= '0;
            mret_reg    <= 1'b0;
        end else if (trap_accept) begin
            pc_reg      <= exc_valid_i ? exc_pc_i : irq_pc_i;
            cause_reg   <= exc_valid_i ? {27'd0, exc_cause_i} : {1'b1, 26'd0, irq_code};
            tval_reg    <= exc_valid_i ? exc_tval_i : 32'd0;
            mstatus_reg <= mstatus_i;
            mtvec_reg   <= mtvec_i;
            mret_reg    <= 1'b0;
        end else if (mret_accept) begin
            pc_reg      <= mepc_i;
            mstatus_reg <= mstatus_i;
            mret_reg    <= 1'b1;
        end
    end

    // mstatus images written on trap entry and on MRET.
    always_comb begin
        trap_mstatus         = mstatus_reg;
        trap_mstatus[7]      = mstatus_reg[3];
        trap_mstatus[3]      = 1'b0;
        trap_mstatus[12:11]  = 2'b11;
        mret_mstatus         = mstatus_reg;
        mret_mstatus[3]      = mstatus_reg[7];
        mret_mstatus[7]      = 1'b1;
        mret_mstatus[12:11]  = 2'b11;
    end

    // Trap vector: vectored mode only applies to interrupts; the add wraps.
    assign trap_base       = {mtvec_reg[31:2], 2'b00};
    assign trap_vectored   = cause_reg[31] & (mtvec_reg[1:0] == 2'b01);
    assign trap_target     = trap_vectored ? (trap_base + {25'd0, cause_reg[4:0], 2'b00})
                                           : trap_base;
    assign redirect_target = mret_reg ? pc_reg : trap_target;

    // Output logic: EX pass-through in quiet IDLE, sequencer writes otherwise.
    // Everything is forced low while reset is held.
    always_comb begin
        csr_we_o         = 1'b0;
        csr_waddr_o      = 32'd0;
        csr_wdata_o      = 32'd0;
        stall_o          = 1'b0;
        flush_o          = 1'b0;
        redirect_valid_o = 1'b0;
        redirect_pc_o    = 32'd0;
        if (rst_ni) begin
            case (state_reg)
                IDLE: begin
                    if (trap_accept || mret_accept) begin
                        // The EX write belongs to the squashed instruction.
                        stall_o = 1'b1;
                        flush_o = 1'b1;
                    end else begin
                        csr_we_o    = ex_csr_we_i;
                        csr_waddr_o = ex_csr_waddr_i;
                        csr_wdata_o = ex_csr_wdata_i;
                    end
                end
                W_MEPC: begin
                    stall_o     = 1'b1;
                    csr_we_o    = 1'b1;
                    csr_waddr_o = MEPC_ADDR;
                    csr_wdata_o = {pc_reg[31:2], 2'b00};
                end
                W_MCAUSE: begin
                    stall_o     = 1'b1;
                    csr_we_o    = 1'b1;
                    csr_waddr_o = MCAUSE_ADDR;
                    csr_wdata_o = cause_reg;
                end
                W_MTVAL: begin
                    stall_o     = 1'b1;
                    csr_we_o    = 1'b1;
                    csr_waddr_o = MTVAL_ADDR;
                    csr_wdata_o = tval_reg;
                end
                W_MSTATUS: begin
                    stall_o     = 1'b1;
                    csr_we_o    = 1'b1;
                    csr_waddr_o = MSTATUS_ADDR;
                    csr_wdata_o = trap_mstatus;
                end
                MRET_WR: begin
                    stall_o     = 1'b1;
                    csr_we_o    = 1'b1;
                    csr_waddr_o = MSTATUS_ADDR;
                    csr_wdata_o = mret_mstatus;
                end
                REDIRECT: begin
                    stall_o          = 1'b1;
                    redirect_valid_o = 1'b1;
                    redirect_pc_o    = redirect_target;
                end
                default: begin
                    csr_we_o = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_csr_trap_ctrl.sv
// Directed bench for csr_trap_ctrl with a write/redirect scoreboard.
module tb_csr_trap_ctrl;

    logic        clk;
    logic        rst_ni;
    logic        ex_csr_we;
    logic [31:0] ex_csr_waddr;
    logic [31:0] ex_csr_wdata;
    logic        exc_valid;
    logic [4:0]  exc_cause;
    logic [31:0] exc_pc;
    logic [31:0] exc_tval;
    logic        irq_ext;
    logic        irq_sw;
    logic        irq_timer;
    logic [31:0] irq_pc;
    logic        mret;
    logic [31:0] mstatus;
    logic [31:0] mie;
    logic [31:0] mtvec;
    logic [31:0] mepc;
    logic        csr_we;
    logic [31:0] csr_waddr;
    logic [31:0] csr_wdata;
    logic        stall;
    logic        flush;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t         wq[$];
    logic [31:0] rq[$];
    int          total = 0;
    int          bad   = 0;

    csr_trap_ctrl dut (
        .clk_i            (clk),
        .rst_ni           (rst_ni),
        .ex_csr_we_i      (ex_csr_we),
        .ex_csr_waddr_i   (ex_csr_waddr),
        .ex_csr_wdata_i   (ex_csr_wdata),
        .exc_valid_i      (exc_valid),
        .exc_cause_i      (exc_cause),
        .exc_pc_i         (exc_pc),
        .exc_tval_i       (exc_tval),
        .irq_ext_i        (irq_ext),
        .irq_sw_i         (irq_sw),
        .irq_timer_i      (irq_timer),
        .irq_pc_i         (irq_pc),
        .mret_i           (mret),
        .mstatus_i        (mstatus),
        .mie_i            (mie),
        .mtvec_i          (mtvec),
        .mepc_i           (mepc),
        .csr_we_o         (csr_we),
        .csr_waddr_o      (csr_waddr),
        .csr_wdata_o      (csr_wdata),
        .stall_o          (stall),
        .flush_o          (flush),
        .redirect_valid_o (redirect_valid),
        .redirect_pc_o    (redirect_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push_w(input logic [31:0] a, input logic [31:0] d);
        wr_t w;
        w.addr = a;
        w.data = d;
        wq.push_back(w);
    endtask

    // Expected trap sequence: mepc, mcause, mtval, mstatus writes, then redirect.
    task automatic push_trap(input logic [31:0] pc, input logic [31:0] cause,
                             input logic [31:0] tval, input logic [31:0] ms,
                             input logic [31:0] target);
        push_w(32'h341, pc);
        push_w(32'h342, cause);
        push_w(32'h343, tval);
        push_w(32'h300, ms);
        rq.push_back(target);
    endtask

    // Sample one cycle 1ns after the inputs settle, check control outputs and
    // pop the scoreboard for any write/redirect seen, then move to the next negedge.
    task automatic sample(input string tag, input logic s, input logic f,
                          input logic w, input logic r);
        wr_t         e;
        logic [31:0] t;
        #1;
        chk({tag, "_stall"}, {31'd0, stall}, {31'd0, s});
        chk({tag, "_flush"}, {31'd0, flush}, {31'd0, f});
        chk({tag, "_we"}, {31'd0, csr_we}, {31'd0, w});
        chk({tag, "_redir_v"}, {31'd0, redirect_valid}, {31'd0, r});
        if (csr_we === 1'b1) begin
            chk({tag, "_wq_avail"}, (wq.size() > 0) ? 32'd1 : 32'd0, 32'd1);
            if (wq.size() > 0) begin
                e = wq.pop_front();
                $display("txn %s: write addr=%h data=%h", tag, csr_waddr, csr_wdata);
                chk({tag, "_waddr"}, csr_waddr, e.addr);
                chk({tag, "_wdata"}, csr_wdata, e.data);
            end
        end
        if (redirect_valid === 1'b1) begin
            chk({tag, "_rq_avail"}, (rq.size() > 0) ? 32'd1 : 32'd0, 32'd1);
            if (rq.size() > 0) begin
                t = rq.pop_front();
                $display("txn %s: redirect pc=%h", tag, redirect_pc);
                chk({tag, "_redir_pc"}, redirect_pc, t);
            end
        end
        @(negedge clk);
    endtask

    // T+1..T+5 of a trap: four writes then the redirect.
    task automatic trap_tail(input string tag);
        sample({tag, "_mepc"},    1'b1, 1'b0, 1'b1, 1'b0);
        sample({tag, "_mcause"},  1'b1, 1'b0, 1'b1, 1'b0);
        sample({tag, "_mtval"},   1'b1, 1'b0, 1'b1, 1'b0);
        sample({tag, "_mstatus"}, 1'b1, 1'b0, 1'b1, 1'b0);
        sample({tag, "_redir"},   1'b1, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        rst_ni = 1'b0;
        ex_csr_we = 1'b1; ex_csr_waddr = 32'h340; ex_csr_wdata = 32'h1111_2222;
        exc_valid = 1'b0; exc_cause = 5'd0; exc_pc = 32'd0; exc_tval = 32'd0;
        irq_ext = 1'b0; irq_sw = 1'b0; irq_timer = 1'b0; irq_pc = 32'd0;
        mret = 1'b0; mstatus = 32'd0; mie = 32'd0; mtvec = 32'd0; mepc = 32'd0;
        repeat (2) @(negedge clk);

        // Reset state: everything low even with an EX write requested.
        sample("reset", 1'b0, 1'b0, 1'b0, 1'b0);
        rst_ni = 1'b1;
        ex_csr_we = 1'b0;
        sample("idle", 1'b0, 1'b0, 1'b0, 1'b0);

        // EX pass-through.
        ex_csr_we = 1'b1; ex_csr_waddr = 32'h340; ex_csr_wdata = 32'hDEAD_BEEF;
        push_w(32'h340, 32'hDEAD_BEEF);
        sample("ex_wr", 1'b0, 1'b0, 1'b1, 1'b0);

        // Synchronous exception; the concurrent EX write must be dropped.
        exc_valid = 1'b1; exc_cause = 5'd2; exc_pc = 32'h8000_0104; exc_tval = 32'h13;
        mstatus = 32'h8; mtvec = 32'h8000_0000;
        push_trap(32'h8000_0104, 32'h2, 32'h13, 32'h1880, 32'h8000_0000);
        sample("exc_T", 1'b1, 1'b1, 1'b0, 1'b0);
        exc_valid = 1'b0; ex_csr_we = 1'b0;
        trap_tail("exc");
        sample("exc_idle", 1'b0, 1'b0, 1'b0, 1'b0);

        // Vectored timer interrupt.
        mie = 32'h80; mtvec = 32'h8000_0001; irq_pc = 32'h200; irq_timer = 1'b1;
        push_trap(32'h200, 32'h8000_0007, 32'h0, 32'h1880, 32'h8000_001C);
        sample("tmr_T", 1'b1, 1'b1, 1'b0, 1'b0);
        irq_timer = 1'b0;
        trap_tail("tmr");
        sample("tmr_idle", 1'b0, 1'b0, 1'b0, 1'b0);

        // Exception beats pending ext+timer; vectored mtvec ignored for exceptions.
        mie = 32'h880; irq_ext = 1'b1; irq_timer = 1'b1; irq_pc = 32'h2004;
        exc_valid = 1'b1; exc_cause = 5'd5; exc_pc = 32'h1000; exc_tval = 32'h55;
        push_trap(32'h1000, 32'h5, 32'h55, 32'h1880, 32'h8000_0000);
        sample("prio_T", 1'b1, 1'b1, 1'b0, 1'b0);
        exc_valid = 1'b0;
        trap_tail("prio_exc");
        // Back in IDLE: ext beats timer.
        push_trap(32'h2004, 32'h8000_000B, 32'h0, 32'h1880, 32'h8000_002C);
        sample("ext_T", 1'b1, 1'b1, 1'b0, 1'b0);
        irq_ext = 1'b0; irq_timer = 1'b0;
        trap_tail("ext");
        sample("ext_idle", 1'b0, 1'b0, 1'b0, 1'b0);

        // MRET.
        mret = 1'b1; mstatus = 32'h1880; mepc = 32'h400;
        push_w(32'h300, 32'h1888);
        rq.push_back(32'h400);
        sample("mret_T", 1'b1, 1'b1, 1'b0, 1'b0);
        mret = 1'b0;
        sample("mret_wr", 1'b1, 1'b0, 1'b1, 1'b0);
        sample("mret_redir", 1'b1, 1'b0, 1'b0, 1'b1);
        sample("mret_idle", 1'b0, 1'b0, 1'b0, 1'b0);

        // Reset in the middle of a trap sequence (during W_MCAUSE).
        exc_valid = 1'b1; exc_cause = 5'd1; exc_pc = 32'h300; exc_tval = 32'h0;
        mstatus = 32'h8; mtvec = 32'h100;
        push_w(32'h341, 32'h300);
        sample("rst_seq_T", 1'b1, 1'b1, 1'b0, 1'b0);
        exc_valid = 1'b0;
        sample("rst_seq_mepc", 1'b1, 1'b0, 1'b1, 1'b0);
        rst_ni = 1'b0;
        ex_csr_we = 1'b1; ex_csr_waddr = 32'h305; ex_csr_wdata = 32'h1234_5678;
        #1;
        chk("rst_mid_waddr", csr_waddr, 32'h0);
        chk("rst_mid_wdata", csr_wdata, 32'h0);
        chk("rst_mid_redir_pc", redirect_pc, 32'h0);
        sample("rst_mid", 1'b0, 1'b0, 1'b0, 1'b0);
        rst_ni = 1'b1;
        push_w(32'h305, 32'h1234_5678);
        sample("post_rst_ex", 1'b0, 1'b0, 1'b1, 1'b0);
        ex_csr_we = 1'b0;
        sample("post_rst_idle", 1'b0, 1'b0, 1'b0, 1'b0);

        chk("wq_left", wq.size(), 32'd0);
        chk("rq_left", rq.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
